// File: rtl/patbuf_pkg.sv
// Shared encodings for the pattern buffer pointer/field sequencer.
package patbuf_pkg;

    localparam logic [1:0] OP_SETBUF   = 2'd0;
    localparam logic [1:0] OP_SETFIELD = 2'd1;
    localparam logic [1:0] OP_INCFIELD = 2'd2;
    localparam logic [1:0] OP_WRITE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Pointer width for n entries, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/patbuf_rr_arb.sv
// Two-way round-robin arbiter; last_grant 0 = A, 1 = B; grant[0] = A, grant[1] = B.
module patbuf_rr_arb (
    input  logic       req_a,
    input  logic       req_b,
    input  logic       enable,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req_a && req_b)
                grant = last_grant ? 2'b01 : 2'b10;
            else
                grant = {req_b, req_a};
        end
    end

endmodule

// File: rtl/patbuf_seq.sv
// Arbitrates two requesters onto the pattern buffer pointer/field port,
// one operation per IDLE -> EXEC -> SETTLE pass.
module patbuf_seq
    import patbuf_pkg::*;
#(
    parameter int buffer_size  = 32,
    parameter int buffer_width = 6,
    parameter int bufp_width   = 3
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           cfg_busy,
    input  logic                           req_a,
    input  logic                           req_b,
    input  logic [1:0]                     op_a,
    input  logic [1:0]                     op_b,
    input  logic [bufp_width-1:0]          buf_a,
    input  logic [bufp_width-1:0]          buf_b,
    input  logic [bufp_width-1:0]          buf2_a,
    input  logic [bufp_width-1:0]          buf2_b,
    input  logic [clog2(buffer_size)-1:0]  fld_a,
    input  logic [clog2(buffer_size)-1:0]  fld_b,
    input  logic [buffer_width-1:0]        wdata_a,
    input  logic [buffer_width-1:0]        wdata_b,
    output logic                           ack_a,
    output logic                           ack_b,
    output logic [buffer_width-1:0]        rdata,
    input  logic [buffer_width-1:0]        field_byte,
    output logic [bufp_width-1:0]          bufp,
    output logic [bufp_width-1:0]          bufp2,
    output logic [clog2(buffer_size)-1:0]  fieldp,
    output logic [buffer_width-1:0]        field_in,
    output logic                           field_write,
    output logic                           busy
);

    localparam int FW = clog2(buffer_size);

    state_t                  state;
    logic                    last_grant;
    logic                    owner;
    logic [1:0]              op_q;
    logic [bufp_width-1:0]   buf_q, buf2_q;
    logic [FW-1:0]           fld_q;
    logic [buffer_width-1:0] wdata_q;
    logic [1:0]              grant;

    // A requester still holds req during its ack cycle; it must not be re-granted then.
    patbuf_rr_arb u_arb (
        .req_a      (req_a & ~ack_a),
        .req_b      (req_b & ~ack_b),
        .enable     ((state == ST_IDLE) && !cfg_busy),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            op_q        <= OP_SETBUF;
            buf_q       <= '0;
            buf2_q      <= '0;
            fld_q       <= '0;
            wdata_q     <= '0;
            bufp        <= '0;
            bufp2       <= '0;
            fieldp      <= '0;
            field_in    <= '0;
            field_write <= 1'b0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b0;
        end else begin
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            field_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner      <= grant[1];
                        last_grant <= grant[1];
                        op_q       <= grant[1] ? op_b    : op_a;
                        buf_q      <= grant[1] ? buf_b   : buf_a;
                        buf2_q     <= grant[1] ? buf2_b  : buf2_a;
                        fld_q      <= grant[1] ? fld_b   : fld_a;
                        wdata_q    <= grant[1] ? wdata_b : wdata_a;
                        busy       <= 1'b1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op_q)
                        OP_SETBUF: begin
                            bufp  <= buf_q;
                            bufp2 <= buf2_q;
                        end
                        OP_SETFIELD: fieldp <= fld_q;
                        OP_INCFIELD:
                            fieldp <= (fieldp == FW'(buffer_size - 1)) ? '0 : fieldp + 1'b1;
                        default: begin
                            field_in    <= wdata_q;
                            field_write <= 1'b1;
                        end
                    endcase
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // The buffer commits a write on this same edge, so forward the written data.
                    rdata <= (op_q == OP_WRITE) ? field_in : field_byte;
                    ack_a <= ~owner;
                    ack_b <= owner;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_patbuf_seq.sv
// Directed bench for patbuf_seq: a 32-field instance with a buffer model, plus a 24-field instance for wrap.
module tb_patbuf_seq;

    logic       clk = 1'b0;
    logic       resetn, cfg_busy;
    logic       req_a, req_b;
    logic [1:0] op_a, op_b;
    logic [2:0] buf_a, buf_b, buf2_a, buf2_b;
    logic [4:0] fld_a, fld_b;
    logic [5:0] wdata_a, wdata_b;
    logic       ack_a, ack_b, field_write, busy;
    logic [5:0] rdata, field_byte, field_in;
    logic [2:0] bufp, bufp2;
    logic [4:0] fieldp;

    logic       ack_a24, ack_b24, field_write24, busy24;
    logic [5:0] rdata24, field_in24;
    logic [5:0] field_byte24 = 6'd0;
    logic [2:0] bufp24, bufp2_24;
    logic [4:0] fieldp24;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    patbuf_seq #(.buffer_size(32), .buffer_width(6), .bufp_width(3)) dut (
        .clk(clk), .resetn(resetn), .cfg_busy(cfg_busy),
        .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
        .buf_a(buf_a), .buf_b(buf_b), .buf2_a(buf2_a), .buf2_b(buf2_b),
        .fld_a(fld_a), .fld_b(fld_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata), .field_byte(field_byte),
        .bufp(bufp), .bufp2(bufp2), .fieldp(fieldp), .field_in(field_in),
        .field_write(field_write), .busy(busy)
    );

    patbuf_seq #(.buffer_size(24), .buffer_width(6), .bufp_width(3)) dut24 (
        .clk(clk), .resetn(resetn), .cfg_busy(cfg_busy),
        .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
        .buf_a(buf_a), .buf_b(buf_b), .buf2_a(buf2_a), .buf2_b(buf2_b),
        .fld_a(fld_a), .fld_b(fld_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a24), .ack_b(ack_b24), .rdata(rdata24), .field_byte(field_byte24),
        .bufp(bufp24), .bufp2(bufp2_24), .fieldp(fieldp24), .field_in(field_in24),
        .field_write(field_write24), .busy(busy24)
    );

    // Buffer model: field i powers up holding (3*i) mod 64, writes commit on the clock edge.
    logic [5:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 6'(i * 3);
        forever begin
            @(posedge clk);
            if (field_write) mem[fieldp] <= field_in;
        end
    end
    assign field_byte = mem[fieldp];

    // Protocol and invariant monitors.
    bit         pend_a = 1'b0, pend_b = 1'b0;
    int         both_ack = 0, ptr_clash = 0, fw_cnt = 0;
    logic [5:0] fw_last = '0;
    logic [2:0] pb = '0, pb2 = '0;
    logic [4:0] pf = '0;

    always @(negedge clk) begin
        if (pend_a) assert (req_a) else $error("req_a dropped before ack");
        if (pend_b) assert (req_b) else $error("req_b dropped before ack");
        if (ack_a && ack_b) both_ack++;
        if (field_write) begin
            fw_cnt++;
            fw_last = field_in;
        end
        if (resetn && (bufp != pb || bufp2 != pb2) && fieldp != pf) ptr_clash++;
        pb  = bufp;
        pb2 = bufp2;
        pf  = fieldp;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [1:0] op, input logic [2:0] b, input logic [2:0] b2,
                         input logic [4:0] f, input logic [5:0] w);
        op_a = op; buf_a = b; buf2_a = b2; fld_a = f; wdata_a = w;
    endtask

    task automatic set_b(input logic [1:0] op, input logic [2:0] b, input logic [2:0] b2,
                         input logic [4:0] f, input logic [5:0] w);
        op_b = op; buf_b = b; buf2_b = b2; fld_b = f; wdata_b = w;
    endtask

    // Issue one op from side (0 = A, 1 = B), wait for its ack, drop req, step past the ack.
    task automatic run_op(input bit side, input logic [1:0] op, input logic [2:0] b,
                          input logic [2:0] b2, input logic [4:0] f, input logic [5:0] w,
                          output int lat, output logic [5:0] rd);
        if (side) begin set_b(op, b, b2, f, w); req_b = 1'b1; pend_b = 1'b1; end
        else      begin set_a(op, b, b2, f, w); req_a = 1'b1; pend_a = 1'b1; end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(side ? ack_b : ack_a) && lat < 20);
        if (lat >= 20) chk("ack_timeout", 32'(lat), 32'd3);
        rd = rdata;
        pend_a = 1'b0; pend_b = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        tick();
        chk("ack_one_cycle", {31'd0, side ? ack_b : ack_a}, 32'd0);
    endtask

    int         lat, n, cyc, bcnt, fw0, ackb_cnt;
    logic [5:0] rd;
    logic [5:0] seq;

    initial begin
        resetn = 1'b0; cfg_busy = 1'b0; req_a = 1'b0; req_b = 1'b0;
        set_a(2'd0, '0, '0, '0, '0);
        set_b(2'd0, '0, '0, '0, '0);
        repeat (3) tick();
        chk("rst_bufp", 32'(bufp), 0);
        chk("rst_bufp2", 32'(bufp2), 0);
        chk("rst_fieldp", 32'(fieldp), 0);
        chk("rst_field_in", 32'(field_in), 0);
        chk("rst_fw", 32'(field_write), 0);
        chk("rst_acks", {30'd0, ack_a, ack_b}, 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        resetn = 1'b1;
        tick();

        // A SETBUF 5/2, stepped edge by edge.
        ackb_cnt = 0;
        set_a(2'd0, 3'd5, 3'd2, 5'd0, 6'd0);
        req_a = 1'b1;
        tick();
        chk("sb_exec_busy", 32'(busy), 1);
        chk("sb_exec_bufp", 32'(bufp), 0);
        ackb_cnt += int'(ack_b);
        tick();
        chk("sb_bufp", 32'(bufp), 5);
        chk("sb_bufp2", 32'(bufp2), 2);
        chk("sb_fieldp", 32'(fieldp), 0);
        chk("sb_no_early_ack", 32'(ack_a), 0);
        ackb_cnt += int'(ack_b);
        tick();
        chk("sb_ack_a", 32'(ack_a), 1);
        chk("sb_rdata", 32'(rdata), 0);
        ackb_cnt += int'(ack_b);
        req_a = 1'b0;
        tick();
        chk("sb_ack_drop", 32'(ack_a), 0);
        chk("sb_idle", 32'(busy), 0);
        ackb_cnt += int'(ack_b);
        chk("sb_ack_b_never", 32'(ackb_cnt), 0);

        // SETFIELD 31 then INCFIELD wraps to 0.
        run_op(1'b0, 2'd1, 3'd0, 3'd0, 5'd31, 6'd0, lat, rd);
        chk("sf31_lat", 32'(lat), 3);
        chk("sf31_fieldp", 32'(fieldp), 31);
        chk("sf31_rdata", 32'(rd), 29);
        run_op(1'b0, 2'd2, 3'd0, 3'd0, 5'd0, 6'd0, lat, rd);
        chk("inc_wrap32", 32'(fieldp), 0);
        chk("inc_wrap32_rd", 32'(rd), 0);
        chk("inc_bufp_held", 32'(bufp), 5);

        // Field 23: wraps on the 24-field instance, increments on the 32-field one.
        run_op(1'b0, 2'd1, 3'd0, 3'd0, 5'd23, 6'd0, lat, rd);
        chk("sf23_f24", 32'(fieldp24), 23);
        run_op(1'b0, 2'd2, 3'd0, 3'd0, 5'd0, 6'd0, lat, rd);
        chk("inc_wrap24", 32'(fieldp24), 0);
        chk("inc_no_wrap32", 32'(fieldp), 24);
        chk("inc24_rdata", 32'(rd), 8);

        // B SETFIELD 7, then B WRITE 2A.
        run_op(1'b1, 2'd1, 3'd0, 3'd0, 5'd7, 6'd0, lat, rd);
        chk("bsf7_rdata", 32'(rd), 21);
        fw0 = fw_cnt;
        run_op(1'b1, 2'd3, 3'd0, 3'd0, 5'd0, 6'h2A, lat, rd);
        chk("wr_lat", 32'(lat), 3);
        chk("wr_pulses", 32'(fw_cnt - fw0), 1);
        chk("wr_field_in", 32'(fw_last), 32'h2A);
        chk("wr_rdata", 32'(rd), 32'h2A);
        chk("wr_mem", 32'(mem[7]), 32'h2A);
        chk("wr_fieldp_held", 32'(fieldp), 7);
        chk("wr_bufp_held", 32'(bufp), 5);

        // Both held: A SETBUF 3/1, B INCFIELD; grants alternate starting with A.
        set_a(2'd0, 3'd3, 3'd1, 5'd0, 6'd0);
        set_b(2'd2, 3'd0, 3'd0, 5'd0, 6'd0);
        req_a = 1'b1; req_b = 1'b1;
        n = 0; cyc = 0; seq = '0;
        while (n < 6 && cyc < 40) begin
            tick();
            cyc++;
            if (ack_a) begin seq[n] = 1'b0; n++; end
            else if (ack_b) begin seq[n] = 1'b1; n++; end
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        chk("rr_ops", 32'(n), 6);
        chk("rr_seq", 32'(seq), 32'b101010);
        chk("rr_cycles", 32'(cyc), 18);
        chk("rr_fieldp", 32'(fieldp), 10);
        chk("rr_bufp", 32'(bufp), 3);
        chk("rr_bufp2", 32'(bufp2), 1);

        // cfg_busy blocks the grant until it drops.
        cfg_busy = 1'b1;
        set_a(2'd1, 3'd0, 3'd0, 5'd4, 6'd0);
        req_a = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            bcnt += int'(busy) + int'(ack_a);
        end
        chk("cfg_blocked", 32'(bcnt), 0);
        cfg_busy = 1'b0;
        tick();
        chk("cfg_exec", 32'(busy), 1);
        tick();
        chk("cfg_no_early_ack", 32'(ack_a), 0);
        tick();
        chk("cfg_ack_a", 32'(ack_a), 1);
        chk("cfg_fieldp", 32'(fieldp), 4);
        req_a = 1'b0;
        tick();

        // Reset during EXEC of a B WRITE.
        set_b(2'd3, 3'd0, 3'd0, 5'd0, 6'h15);
        req_b = 1'b1;
        tick();
        chk("rw_exec", 32'(busy), 1);
        fw0 = fw_cnt;
        resetn = 1'b0;
        #1;
        chk("rw_busy", 32'(busy), 0);
        chk("rw_bufp", 32'(bufp), 0);
        chk("rw_bufp2", 32'(bufp2), 0);
        chk("rw_fieldp", 32'(fieldp), 0);
        chk("rw_fw", 32'(field_write), 0);
        req_b = 1'b0;
        ackb_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ackb_cnt += int'(ack_b);
        end
        chk("rw_no_ack", 32'(ackb_cnt), 0);
        chk("rw_no_write", 32'(fw_cnt - fw0), 0);
        resetn = 1'b1;
        tick();

        // After reset A wins the tie again.
        set_a(2'd0, 3'd6, 3'd7, 5'd0, 6'd0);
        set_b(2'd1, 3'd0, 3'd0, 5'd9, 6'd0);
        req_a = 1'b1; req_b = 1'b1;
        cyc = 0;
        while (!ack_a && !ack_b && cyc < 20) begin tick(); cyc++; end
        chk("post_rst_first_a", {30'd0, ack_a, ack_b}, 32'b10);
        chk("post_rst_lat", 32'(cyc), 3);
        chk("post_rst_bufp", 32'(bufp), 6);
        chk("post_rst_fieldp", 32'(fieldp), 0);
        req_a = 1'b0;
        cyc = 0;
        while (!ack_b && cyc < 20) begin tick(); cyc++; end
        chk("post_rst_b_lat", 32'(cyc), 3);
        chk("post_rst_b_fieldp", 32'(fieldp), 9);
        req_b = 1'b0;
        tick();

        chk("acks_exclusive", 32'(both_ack), 0);
        chk("ptr_field_clash", 32'(ptr_clash), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/patbuf_seq.md
Name: patbuf_seq

Overview:
Sequencer and arbiter for the pattern buffer pointer/field port (bufp, bufp2, fieldp, field_in, field_write, field_byte). Two requesters issue buffer-select, field-pointer and field-write operations: A is the pattern core and B is the debug/host path. The block arbitrates round-robin, runs one operation at a time and enforces that bufp and fieldp never change in the same cycle. It stalls while serial configuration (ssel) is active and returns read data with a one-cycle ack.

Parameters:
buffer_size, 32, number of fields per buffer; fieldp width is clog2(buffer_size)
buffer_width, 6, field data width
bufp_width, 3, buffer select pointer width

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous, active-low reset
cfg_busy  input  1  serial config active (ssel); no new grant while high
req_a / req_b  input  1  request; held with args stable until ack
op_a / op_b  input  2  0 SETBUF, 1 SETFIELD, 2 INCFIELD, 3 WRITE
buf_a / buf_b  input  bufp_width  bufp value for SETBUF
buf2_a / buf2_b  input  bufp_width  bufp2 value for SETBUF
fld_a / fld_b  input  clog2(buffer_size)  fieldp value for SETFIELD
wdata_a / wdata_b  input  buffer_width  data for WRITE
ack_a / ack_b  output  1  one-cycle completion pulse
rdata  output  buffer_width  field_byte at fieldp after op; valid with ack
field_byte  input  buffer_width  buffer read data
bufp / bufp2  output  bufp_width  buffer pointers to buffers
fieldp  output  clog2(buffer_size)  field pointer
field_in  output  buffer_width  write data
field_write  output  1  write strobe, one cycle
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async on resetn low): bufp=0, bufp2=0, fieldp=0, field_in=0, field_write=0, ack_a=ack_b=0, rdata=0, busy=0, state IDLE, last_grant=B (so A wins the first tie).
- FSM has three states: IDLE -> EXEC -> SETTLE -> IDLE. One operation takes 3 cycles; throughput is at most one op per 3 cycles.
- IDLE: if cfg_busy=1, no grant. Otherwise, if exactly one req is high, grant it. If both are high, grant the requester not in last_grant. Latch op and args, update last_grant, go to EXEC.
- EXEC, by latched op:
  - SETBUF: bufp and bufp2 take the arguments; fieldp is held.
  - SETFIELD: fieldp takes fld.
  - INCFIELD: fieldp is incremented; buffer_size-1 wraps to 0, and wrap works for non-power-of-2 sizes.
  - WRITE: field_in takes wdata and field_write=1 for this cycle only; pointers are held.
  - In all cases bufp/bufp2 and fieldp are never both modified in one cycle.
- SETTLE: rdata is registered from field_byte, the ack of the granted requester pulses high for one cycle, then return to IDLE. For WRITE, rdata reflects the post-write value, since field_write is registered through the buffer one cycle.
- Requesters must drop req or present a new op in the cycle after ack. A req still high in IDLE is treated as a new request.
- cfg_busy rising during EXEC or SETTLE: the current op completes; only new grants are blocked.
- A req deasserted before ack: the op still completes and ack is still pulsed; the protocol violation is flagged by a bench assertion.
- resetn low mid-op: the op is aborted, no ack is issued, and all outputs go to reset values immediately.
- ack_a and ack_b are never high together. field_write is never high outside EXEC.

Decomposition:
- Shared package patbuf_pkg holds the op encoding constants (OP_SETBUF=0, OP_SETFIELD=1, OP_INCFIELD=2, OP_WRITE=3), state encoding, and the fieldp width function clog2(buffer_size).
- One sub-module, patbuf_rr_arb: 2-way round-robin arbiter with req_a, req_b, enable and last_grant in, grant one-hot out.
- FSM and datapath registers stay in patbuf_seq.

Test Plan:
- Reset then A SETBUF buf=5 buf2=2 -> bufp=5, bufp2=2 in cycle 2, ack_a in cycle 3, fieldp stays 0, ack_b never high.
- A SETFIELD 31 then A INCFIELD -> fieldp 31 then 0 (wrap). With buffer_size=24, INCFIELD at 23 -> 0.
- B WRITE wdata=6'h2A at fieldp=7 -> field_write high exactly 1 cycle with field_in=2A; ack_b with rdata=2A.
- req_a and req_b held continuously, 6 ops total -> grants alternate A,B,A,B,A,B; a checker sees bufp and fieldp never change in the same cycle.
- cfg_busy high with req_a pending -> no grant for 10 cycles; cfg_busy low -> EXEC on the next cycle, ack_a 2 cycles later.
- resetn pulsed low during EXEC of a WRITE -> no ack, field_write=0, pointers=0; the next request is served normally, with A winning.
